// File: rtl/alu_rvs_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rvs_sched
//  Description : Round-robin scheduler that shares one external alu_rvs
//                bit-reversal unit among NREQ requesters. A winning request
//                is registered into the ALU operand registers. The ALU result
//                is captured one cycle later and returned on a single
//                response channel, tagged with the requester index.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREQ      : number of requesters (2..8)
//    IDW       : requester index width, clog2(NREQ)
//  Ports
//    clk       : clock, rising edge
//    rst_n     : asynchronous active-low reset
//    req_valid : per-requester request valid          [NREQ]
//    req_ready : per-requester accept, one-hot or 0   [NREQ]
//    req_din   : packed operands, slot i = [32*i +: 32]
//    req_funct : packed function codes, slot i = [3*i +: 3]
//    alu_din   : registered operand to alu_rvs.din
//    alu_funct : registered function code to alu_rvs.funct
//    alu_res   : alu_rvs.res (combinational from alu_din/alu_funct)
//    rsp_valid : response valid
//    rsp_ready : response accept
//    rsp_data  : captured ALU result
//    rsp_id    : index of the requester served
//    rsp_err   : function code was 5, 6 or 7
//    op_cnt    : completed-response counter, wraps at 16 bits
// ============================================================================
module alu_rvs_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_din,
  input  logic [3*NREQ-1:0]   req_funct,
  output logic [31:0]         alu_din,
  output logic [2:0]          alu_funct,
  input  logic [31:0]         alu_res,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic [15:0]         op_cnt
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  // One extra bit so that index + offset never overflows before the modulo.
  localparam logic [IDW:0] c_NREQ = (IDW+1)'(NREQ);
  localparam logic [IDW:0] c_ONE  = (IDW+1)'(1);

  // Highest function code that is a defined reversal; anything above errors.
  localparam logic [2:0]   c_MAX_FUNCT = 3'd4;

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_ptr;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [NREQ-1:0] w_gnt;
  logic            w_hs;

  // --------------------------------------------------------------------------
  // (base + off) mod NREQ. Both operands are below NREQ, so a single
  // conditional subtract is enough.
  // --------------------------------------------------------------------------
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input logic [IDW:0]   off);
    logic [IDW:0] s;
    s = {1'b0, base} + off;
    if (s >= c_NREQ) begin
      s = s - c_NREQ;
    end
    return s[IDW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Round-robin arbiter: the first valid request at or after r_ptr wins.
  // The loop runs from the farthest offset down to offset 0, so the nearest
  // valid candidate is the last one written and takes precedence.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[wrap_add(r_ptr, k[IDW:0])]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, k[IDW:0]);
      end
    end
  end

  // A grant is offered only while idle.
  always_comb begin
    w_gnt = '0;
    if ((r_state == c_IDLE) && w_found) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  // req_ready is combinational from req_valid. Gating it with rst_n keeps it
  // low for the whole reset pulse, even though the FSM already sits in IDLE.
  assign req_ready = w_gnt & {NREQ{rst_n}};

  // The winner's own valid is high by construction, so any grant is a handshake.
  assign w_hs = |w_gnt;

  assign rsp_valid = (r_state == c_RESP);

  // --------------------------------------------------------------------------
  // FSM and the priority pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_hs) begin
            // The pointer moves only on a grant, to the slot after the winner.
            r_ptr   <= wrap_add(w_win, c_ONE);
            r_state <= c_EXEC;
          end
        end
        c_EXEC: begin
          r_state <= c_RESP;
        end
        c_RESP: begin
          if (rsp_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // ALU operand registers: loaded only on a grant, so the ALU input stays
  // stable through EXEC and RESP.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_din   <= '0;
      alu_funct <= '0;
      rsp_id    <= '0;
    end else if (w_hs) begin
      alu_din   <= req_din[32*w_win +: 32];
      alu_funct <= req_funct[3*w_win +: 3];
      rsp_id    <= w_win;
    end
  end

  // --------------------------------------------------------------------------
  // Result capture. Undefined codes are passed through unchanged and only
  // flagged here.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (r_state == c_EXEC) begin
      rsp_data <= alu_res;
      rsp_err  <= (alu_funct > c_MAX_FUNCT);
    end
  end

  // --------------------------------------------------------------------------
  // Completed-response counter. It counts on the response handshake only,
  // so a transaction aborted by reset is never counted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if ((r_state == c_RESP) && rsp_ready) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rvs_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rvs_sched
//  Description : Self-checking bench for alu_rvs_sched with a behavioural
//                alu_rvs model, directed vectors and a randomized scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rvs_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_din;
  logic [3*NREQ-1:0]   req_funct;
  logic [31:0]         alu_din;
  logic [2:0]          alu_funct;
  logic [31:0]         alu_res;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;
  logic [15:0]         op_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = '0;

  alu_rvs_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din   (req_din),
    .req_funct (req_funct),
    .alu_din   (alu_din),
    .alu_funct (alu_funct),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  // alu_rvs model: reverse bit order inside each group of 2**funct bits.
  function automatic logic [31:0] alu_model(input logic [31:0] d, input logic [2:0] f);
    logic [31:0] r;
    int g;
    if (f > 3'd4) return 32'hDEADBEEF;
    g = 1 << f;
    r = '0;
    for (int i = 0; i < 32; i++) r[(i/g)*g + (g-1-(i%g))] = d[i];
    return r;
  endfunction

  always_comb alu_res = alu_model(alu_din, alu_funct);

  // Reference result built differently: successive block-swap stages.
  function automatic logic [31:0] ref_rev(input logic [31:0] d, input logic [2:0] f);
    logic [31:0] r;
    if (f > 3'd4) return 32'hDEADBEEF;
    r = d;
    if (f >= 3'd1) r = ((r & 32'h55555555) << 1) | ((r >> 1) & 32'h55555555);
    if (f >= 3'd2) r = ((r & 32'h33333333) << 2) | ((r >> 2) & 32'h33333333);
    if (f >= 3'd3) r = ((r & 32'h0F0F0F0F) << 4) | ((r >> 4) & 32'h0F0F0F0F);
    if (f >= 3'd4) r = ((r & 32'h00FF00FF) << 8) | ((r >> 8) & 32'h00FF00FF);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  req_ready, '0);
    chk({tag, "_alu_din"}, alu_din, '0);
    chk({tag, "_alu_fn"}, alu_funct, '0);
    chk({tag, "_rspv"},   rsp_valid, '0);
    chk({tag, "_data"},   rsp_data, '0);
    chk({tag, "_id"},     rsp_id, '0);
    chk({tag, "_err"},    rsp_err, '0);
    chk({tag, "_opcnt"},  op_cnt, '0);
  endtask

  task automatic set_slot(input int id, input logic [31:0] d, input logic [2:0] f);
    req_din[32*id +: 32] = d;
    req_funct[3*id +: 3] = f;
  endtask

  // Starts and ends at a negedge with the DUT idle.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = '0;
  endtask

  // Wait (bounded) for rsp_valid, sampling at negedges.
  task automatic wait_rsp(input string tag);
    bit got = 0;
    for (int w = 0; w < 4 && !got; w++) begin
      #1;
      if (rsp_valid) got = 1;
      else begin @(posedge clk); @(negedge clk); end
    end
    chk({tag, "_rsp_timeout"}, got, 1);
  endtask

  // One isolated transaction from a single requester. Called at a negedge, DUT idle.
  task automatic run_txn(input string tag, input int id, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] exp_d, input logic exp_e);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    set_slot(id, d, f);
    req_valid = oh;
    #1 chk({tag, "_ready"}, req_ready, oh);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    chk({tag, "_exec_rspv"}, rsp_valid, 0);
    chk({tag, "_alu_din"}, alu_din, d);
    chk({tag, "_alu_fn"}, alu_funct, f);
    wait_rsp(tag);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_err"}, rsp_err, exp_e);
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_opcnt"}, op_cnt, exp_cnt);
    chk({tag, "_done_rspv"}, rsp_valid, 0);
  endtask

  typedef struct {
    string       name;
    int          id;
    logic [31:0] din;
    logic [2:0]  funct;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];
  int   exp_order[6] = '{0, 1, 2, 3, 0, 1};

  // Randomized run against an abstract scoreboard: pending set, pointer,
  // one outstanding job with its grant cycle, and an expected count.
  task automatic run_random(input int ncyc);
    logic [NREQ-1:0] pend;
    logic [31:0]     pdin [NREQ];
    logic [2:0]      pfn  [NREQ];
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     e_data;
    logic            e_err;
    int              e_id;
    int              mptr;
    int              gcyc;
    int              win;
    bit              busy;
    bit              rv_exp;
    pend = '0; mptr = 0; gcyc = 0; busy = 0; e_id = 0; e_data = '0; e_err = 0;
    for (int i = 0; i < NREQ; i++) begin pdin[i] = '0; pfn[i] = '0; end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pdin[i] = $urandom;
          pfn[i]  = 3'($urandom_range(0, 7));
        end
        set_slot(i, pdin[i], pfn[i]);
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      win = -1;
      if (!busy) begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (mptr + k) % NREQ;
          if (win < 0 && pend[j]) win = j;
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      rv_exp = busy && (c >= gcyc + 1);
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_rspv", rsp_valid, rv_exp);
      chk("rnd_opcnt", op_cnt, exp_cnt);
      if (rv_exp) begin
        chk("rnd_data", rsp_data, e_data);
        chk("rnd_id", rsp_id, e_id);
        chk("rnd_err", rsp_err, e_err);
      end
      if (rv_exp && rsp_ready) begin
        busy = 0;
        exp_cnt++;
      end else if (win >= 0) begin
        busy   = 1;
        gcyc   = c + 1;
        e_id   = win;
        e_data = ref_rev(pdin[win], pfn[win]);
        e_err  = (pfn[win] > 3'd4);
        pend[win] = 1'b0;
        mptr   = (win + 1) % NREQ;
      end
      @(posedge clk); @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] hold_d;
    int nseen;
    int last;

    vecs[0] = '{"r1_f3",  1, 32'h12345678, 3'd3, 32'h482C6A1E, 1'b0};
    vecs[1] = '{"r0_f4",  0, 32'h00000001, 3'd4, 32'h00008000, 1'b0};
    vecs[2] = '{"r0_f1",  0, 32'h00000001, 3'd1, 32'h00000002, 1'b0};
    vecs[3] = '{"r0_f0",  0, 32'h00000001, 3'd0, 32'h00000001, 1'b0};
    vecs[4] = '{"r2_f7",  2, 32'hFFFFFFFF, 3'd7, 32'hDEADBEEF, 1'b1};
    vecs[5] = '{"r3_f2",  3, 32'h12345678, 3'd2, 32'h84C2A6E1, 1'b0};
    vecs[6] = '{"r3_f4",  3, 32'h12345678, 3'd4, 32'h2C481E6A, 1'b0};
    vecs[7] = '{"r1_f5",  1, 32'h00000000, 3'd5, 32'hDEADBEEF, 1'b1};
    vecs[8] = '{"r2_f6",  2, 32'h0000FFFF, 3'd6, 32'hDEADBEEF, 1'b1};

    // Reset values, with every request asserted to prove req_ready is gated.
    rst_n     = 1'b0;
    req_valid = '1;
    req_din   = '1;
    req_funct = '1;
    rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 chk_reset_vals("reset");
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].id, vecs[i].din, vecs[i].funct,
              vecs[i].exp_data, vecs[i].exp_err);

    // Response backpressure: hold for 5 cycles with other requests pending.
    set_slot(3, 32'h0F00F00F, 3'd3);
    req_valid = 4'b1000;
    @(posedge clk); @(negedge clk);
    req_valid = 4'b0011;
    wait_rsp("hold");
    hold_d = ref_rev(32'h0F00F00F, 3'd3);
    for (int h = 0; h < 5; h++) begin
      chk("hold_rspv", rsp_valid, 1);
      chk("hold_data", rsp_data, hold_d);
      chk("hold_id", rsp_id, 3);
      chk("hold_ready", req_ready, 0);
      chk("hold_opcnt", op_cnt, exp_cnt);
      @(posedge clk); @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("hold_done_opcnt", op_cnt, exp_cnt);
    chk("hold_done_rspv", rsp_valid, 0);
    chk("hold_next_grant", req_ready, 4'b0001);
    req_valid = '0;
    @(negedge clk);

    // Reset during EXEC: requester 1 granted (pointer moves to 2), then abort.
    set_slot(1, 32'hCAFEF00D, 3'd2);
    req_valid = 4'b0010;
    @(posedge clk); @(negedge clk);
    req_valid = 4'b0101;
    chk("abort_exec_rspv", rsp_valid, 0);
    chk("abort_exec_din", alu_din, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    #1 chk("abort_first_grant", req_ready, 4'b0001);
    req_valid = '0;
    @(negedge clk);

    // All requesters continuously valid from reset: strict rotation, 3-cycle spacing.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_slot(i, 32'hA5A50F0F ^ i, 3'(i));
    req_valid = '1;
    rsp_ready = 1'b1;
    nseen = 0;
    last  = 0;
    for (int c = 0; c < 40 && nseen < 6; c++) begin
      #1;
      if (rsp_valid) begin
        chk("rr_id", rsp_id, exp_order[nseen]);
        chk("rr_data", rsp_data, ref_rev(32'hA5A50F0F ^ exp_order[nseen], 3'(exp_order[nseen])));
        if (nseen > 0) chk("rr_gap", c - last, 3);
        last = c;
        nseen++;
      end
      @(posedge clk); @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("rr_count", nseen, 6);
    exp_cnt = exp_cnt + 16'(nseen);
    #1 chk("rr_opcnt", op_cnt, exp_cnt);
    @(negedge clk);

    // Randomized traffic against the scoreboard
    do_reset();
    run_random(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
